// File: rtl/coproc_pkg.sv
// coproc_pkg
// Shared types and constants for the buffer coprocessor blocks: the read-back
// controller and the loader share the command constants, the buffer depth and
// the read controller state type.
// Ports: none (package).

package coproc_pkg;

   // Read controller states: one BRAM fetch, one latch of the read data,
   // a hand-off to the transmitter, then a wait for the frame to drain.
   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      LATCH,
      SEND,
      DRAIN
   } read_state_t;

   // ASCII "rd\n" starts a read-back, "ra\n" starts a load.
   localparam logic [23:0] CMD_READ  = 24'h72640A;
   localparam logic [23:0] CMD_WRITE = 24'h72610A;

   localparam int DEPTH_DEFAULT = 1024;

endpackage

// File: rtl/cmd_detector.sv
// cmd_detector
// Watches the UART receive stream for a three-byte command and raises a
// registered single-cycle match pulse on the cycle after the final byte.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   byte_received   byte from the UART receiver
//   rx_data_ready   single-cycle strobe qualifying byte_received
//   enable          when low, received bytes are ignored entirely
//   clear           flushes the history (takes priority over a new byte)
//   match           registered pulse: last three bytes equal CMD

module cmd_detector
   import coproc_pkg::*;
#(
   parameter logic [23:0] CMD = CMD_READ
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] byte_received,
   input  logic       rx_data_ready,
   input  logic       enable,
   input  logic       clear,
   output logic       match
);

   logic [23:0] shift_q, shift_d;
   logic        match_q, match_d;
   logic [23:0] shifted;

   assign shifted = {shift_q[15:0], byte_received};

   // The match is judged on the post-shift history so the pulse lands one
   // cycle after the final byte strobe. Clearing wipes the history so a
   // trailing newline after a command cannot complete a second match.
   always_comb begin
      shift_d = shift_q;
      match_d = 1'b0;
      if (clear) begin
         shift_d = 24'h0;
      end else if (enable && rx_data_ready) begin
         shift_d = shifted;
         match_d = (shifted == CMD);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shift_q <= 24'h0;
         match_q <= 1'b0;
      end else begin
         shift_q <= shift_d;
         match_q <= match_d;
      end
   end

   assign match = match_q;

endmodule

// File: rtl/read_controller.sv
// read_controller
// Streams the whole BRAM buffer out through the UART transmitter, one byte per
// frame, each time the host sends "rd\n".
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   byte_received   byte from the UART receiver
//   rx_data_ready   receiver strobe
//   dout            BRAM read data, valid the cycle after en
//   tx_busy         transmitter busy flag
//   en, addr        BRAM read port (read only)
//   tx_start        single-cycle transmit request
//   tx_data         byte being transmitted, held until the frame ends
//   busy            high while a transfer is in progress

module read_controller
   import coproc_pkg::*;
#(
   parameter int DEPTH  = DEPTH_DEFAULT,
   parameter int ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [7:0]        byte_received,
   input  logic              rx_data_ready,
   input  logic [7:0]        dout,
   input  logic              tx_busy,
   output logic              en,
   output logic [ADDR_W-1:0] addr,
   output logic              tx_start,
   output logic [7:0]        tx_data,
   output logic              busy
);

   // End-of-buffer is tested at the address width, so the last address is
   // reached exactly rather than relying on a wrap to DEPTH.
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

   read_state_t       state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [7:0]        tx_data_q, tx_data_d;
   logic              guard_q, guard_d;
   logic              cmd_match;
   logic              det_clear;
   logic              det_enable;

   // Commands are only listened for while idle, so a repeated "rd\n" in the
   // middle of a transfer neither restarts nor extends it.
   assign det_enable = (state_q == IDLE);

   cmd_detector #(
      .CMD (CMD_READ)
   ) u_cmd_detector (
      .clk           (clk),
      .rst_n         (rst_n),
      .byte_received (byte_received),
      .rx_data_ready (rx_data_ready),
      .enable        (det_enable),
      .clear         (det_clear),
      .match         (cmd_match)
   );

   // Next-state and outputs. tx_start is combinational on tx_busy so the
   // request is never raised while the transmitter is still busy. The DRAIN
   // guard cycle skips the cycle where tx_busy has not yet risen in response
   // to the request just made.
   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      tx_data_d = tx_data_q;
      guard_d   = guard_q;
      en        = 1'b0;
      tx_start  = 1'b0;
      det_clear = 1'b0;
      case (state_q)
         IDLE: begin
            addr_d = '0;
            if (cmd_match) begin
               det_clear = 1'b1;
               state_d   = FETCH;
            end
         end
         FETCH: begin
            en      = 1'b1;
            state_d = LATCH;
         end
         LATCH: begin
            tx_data_d = dout;
            state_d   = SEND;
         end
         SEND: begin
            if (!tx_busy) begin
               tx_start = 1'b1;
               guard_d  = 1'b1;
               state_d  = DRAIN;
            end
         end
         DRAIN: begin
            if (guard_q) begin
               guard_d = 1'b0;
            end else if (!tx_busy) begin
               if (addr_q == LAST_ADDR) begin
                  addr_d  = '0;
                  state_d = IDLE;
               end else begin
                  addr_d  = addr_q + ADDR_W'(1);
                  state_d = FETCH;
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         addr_q    <= '0;
         tx_data_q <= 8'h00;
         guard_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         tx_data_q <= tx_data_d;
         guard_q   <= guard_d;
      end
   end

   assign addr    = addr_q;
   assign tx_data = tx_data_q;
   assign busy    = (state_q != IDLE);

endmodule
